// File: rtl/mau_window_ctrl.sv
// ============================================================================
// mau_window_ctrl : sequencer for the 7x7 line-memory window unit; paces the
//                   pixel stream, injects end-of-frame padding shifts and
//                   tags each window with its centre coordinates.
// Revision 1.0
// ============================================================================
`default_nettype none

module mau_window_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COL_W      = 10,
   parameter int ROW_W      = 9,
   parameter int PIX_W      = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic             in_ready,
   output logic             mau_data_enable,
   output logic             mau_pad_sel,
   output logic             out_valid,
   output logic [ROW_W-1:0] out_row,
   output logic [COL_W-1:0] out_col,
   output logic             out_border,
   output logic             frame_done,
   output logic             busy,
   output logic             sof_err
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH} state_t;

   localparam logic [PIX_W-1:0] FILL_N    = PIX_W'(3*IMG_WIDTH + 3);
   localparam logic [PIX_W-1:0] NPIX_M1   = PIX_W'(IMG_WIDTH*IMG_HEIGHT - 1);
   localparam logic [PIX_W-1:0] FLUSH_END = PIX_W'(IMG_WIDTH*IMG_HEIGHT + 3*IMG_WIDTH + 2);
   localparam logic [PIX_W-1:0] PIX_ONE   = PIX_W'(1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_HI    = COL_W'(IMG_WIDTH - 4);
   localparam logic [COL_W-1:0] COL_LO    = COL_W'(3);
   localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_HI    = ROW_W'(IMG_HEIGHT - 4);
   localparam logic [ROW_W-1:0] ROW_LO    = ROW_W'(3);
   localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

   state_t           state_q;
   logic [PIX_W-1:0] in_cnt_q, shift_cnt_q;
   logic [ROW_W-1:0] row_q, r1_q, out_row_q;
   logic [COL_W-1:0] col_q, c1_q, out_col_q;
   logic             v1_q, b1_q, l1_q;
   logic             out_valid_q, out_border_q, frame_done_q, sof_err_q;

   logic acc, restart, streaming, kill, shift, win, border_d, last_d;

   assign in_ready  = ~reset & (state_q != S_FLUSH);
   assign acc       = in_valid & in_ready;
   assign restart   = acc & in_sof;
   assign streaming = (state_q == S_FILL) | (state_q == S_STREAM);
   assign kill      = restart & streaming;
   assign shift     = ((state_q == S_FLUSH) & ~reset) | restart | (acc & streaming);
   // The restart shift is pixel 0 of a new frame, so it never yields a window.
   assign win       = shift & ~restart & (shift_cnt_q >= FILL_N);

   assign border_d = (row_q < ROW_LO) | (row_q > ROW_HI) | (col_q < COL_LO) | (col_q > COL_HI);
   assign last_d   = (row_q == ROW_LAST) & (col_q == COL_LAST);

   assign mau_data_enable = shift;
   assign mau_pad_sel     = (state_q == S_FLUSH) & ~reset;
   assign busy            = (state_q != S_IDLE);
   assign out_valid       = out_valid_q;
   assign out_row         = out_row_q;
   assign out_col         = out_col_q;
   assign out_border      = out_border_q;
   assign frame_done      = frame_done_q;
   assign sof_err         = sof_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         in_cnt_q     <= '0;
         shift_cnt_q  <= '0;
         row_q        <= '0;
         col_q        <= '0;
         v1_q         <= 1'b0;
         r1_q         <= '0;
         c1_q         <= '0;
         b1_q         <= 1'b0;
         l1_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_border_q <= 1'b0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
      end else begin
         sof_err_q <= kill;

         // Two-stage tag pipeline tracks the window unit's cell + output registers.
         v1_q <= win;
         if (win) begin
            r1_q <= row_q;
            c1_q <= col_q;
            b1_q <= border_d;
            l1_q <= last_d;
         end
         out_valid_q  <= v1_q & ~kill;
         frame_done_q <= v1_q & ~kill & l1_q;
         if (v1_q & ~kill) begin
            out_row_q    <= r1_q;
            out_col_q    <= c1_q;
            out_border_q <= b1_q;
         end

         if (restart) begin
            row_q <= '0;
            col_q <= '0;
         end else if (win) begin
            if (col_q == COL_LAST) begin
               col_q <= '0;
               row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
            end else begin
               col_q <= col_q + COL_ONE;
            end
         end

         if (restart) begin
            state_q     <= S_FILL;
            in_cnt_q    <= PIX_ONE;
            shift_cnt_q <= PIX_ONE;
         end else begin
            case (state_q)
               S_FILL, S_STREAM: begin
                  if (acc) begin
                     in_cnt_q    <= in_cnt_q + PIX_ONE;
                     shift_cnt_q <= shift_cnt_q + PIX_ONE;
                     if (in_cnt_q == NPIX_M1)
                        state_q <= S_FLUSH;
                     else if (shift_cnt_q == FILL_N)
                        state_q <= S_STREAM;
                  end
               end
               S_FLUSH: begin
                  shift_cnt_q <= shift_cnt_q + PIX_ONE;
                  if (shift_cnt_q == FLUSH_END)
                     state_q <= S_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mau_window_ctrl.sv
// ============================================================================
// tb_mau_window_ctrl : randomized scoreboard bench for mau_window_ctrl (8x8).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mau_window_ctrl;

   localparam int W       = 8;
   localparam int H       = 8;
   localparam int NPIX    = W * H;
   localparam int FILL_N  = 3 * W + 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sof = 1'b0;
   logic       in_ready, mau_data_enable, mau_pad_sel, out_valid;
   logic [8:0] out_row;
   logic [9:0] out_col;
   logic       out_border, frame_done, busy, sof_err;

   mau_window_ctrl #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .COL_W     (10),
      .ROW_W     (9),
      .PIX_W     (20)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_sof         (in_sof),
      .in_ready       (in_ready),
      .mau_data_enable(mau_data_enable),
      .mau_pad_sel    (mau_pad_sel),
      .out_valid      (out_valid),
      .out_row        (out_row),
      .out_col        (out_col),
      .out_border     (out_border),
      .frame_done     (frame_done),
      .busy           (busy),
      .sof_err        (sof_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int row;
      int col;
      bit border;
      bit last;
   } win_t;

   win_t exp_q[$];
   int   sof_q[$];
   win_t m_e;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   int  nb_cnt = 0;
   int  fd_cnt = 0;
   bit  mon_en = 1'b0;

   // Reference model state: frame activity, accepted-pixel count, window index.
   bit  active = 1'b0;
   int  pix = 0;
   int  widx = 0;
   int  flush_left = 0;
   bit  last_acc = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic purge(input int lim);
      while (exp_q.size() > 0 && exp_q[$].due >= lim) void'(exp_q.pop_back());
      while (sof_q.size() > 0 && sof_q[$] >= lim) void'(sof_q.pop_back());
   endtask

   task automatic push_win();
      win_t e;
      e.due    = cyc + 2;
      e.row    = widx / W;
      e.col    = widx % W;
      e.border = (e.row < 3) || (e.row > H - 4) || (e.col < 3) || (e.col > W - 4);
      e.last   = (widx == NPIX - 1);
      exp_q.push_back(e);
      widx++;
   endtask

   task automatic cycle(input bit v, input bit s, input bit r);
      bit er, een, acc;
      @(posedge clk);
      #1;
      reset    = r;
      in_valid = v;
      in_sof   = s;
      @(negedge clk);
      er  = !r && (flush_left == 0);
      acc = v && er;
      een = !r && ((flush_left > 0) || (acc && (s || active)));
      chk("in_ready", int'(in_ready), int'(er));
      chk("data_enable", int'(mau_data_enable), int'(een));
      chk("pad_sel", int'(mau_pad_sel), int'(!r && flush_left > 0));
      chk("busy", int'(busy), int'(active));
      last_acc = acc;
      if (r) begin
         purge(cyc + 1);
         active = 0; flush_left = 0; pix = 0; widx = 0;
      end else if (flush_left > 0) begin
         push_win();
         flush_left--;
         if (flush_left == 0) active = 0;
      end else if (acc && s) begin
         if (active) begin
            purge(cyc + 1);
            sof_q.push_back(cyc + 1);
         end
         active = 1; pix = 1; widx = 0;
      end else if (acc && active) begin
         pix++;
         if (pix > FILL_N) push_win();
         if (pix == NPIX) flush_left = FILL_N;
      end
   endtask

   task automatic send_pixel(input bit sof, input int gap_pct);
      bit v;
      int tries = 0;
      do begin
         v = ($urandom_range(99) >= gap_pct);
         cycle(v, sof & v, 1'b0);
         tries++;
      end while (!last_acc && tries < 1000);
      if (!last_acc) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got %0d tries expected acceptance", tries);
      end
   endtask

   task automatic send_pixels(input int n, input int gap_pct);
      for (int i = 0; i < n; i++) send_pixel(i == 0, gap_pct);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("valid_unexpected", int'(out_valid), 0);
            end else begin
               m_e = exp_q.pop_front();
               chk("due_cycle", cyc, m_e.due);
               chk("row", int'(out_row), m_e.row);
               chk("col", int'(out_col), m_e.col);
               chk("border", int'(out_border), int'(m_e.border));
               chk("frame_done", int'(frame_done), int'(m_e.last));
               if (!out_border) nb_cnt++;
               if (frame_done) fd_cnt++;
            end
         end else begin
            chk("frame_done_idle", int'(frame_done), 0);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               chk("valid_missing", int'(out_valid), 1);
               void'(exp_q.pop_front());
            end
         end
         if (sof_q.size() > 0 && sof_q[0] == cyc) begin
            chk("sof_err", int'(sof_err), 1);
            void'(sof_q.pop_front());
         end else begin
            chk("sof_err_idle", int'(sof_err), 0);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      cycle(1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_row", int'(out_row), 0);
      chk("reset_out_col", int'(out_col), 0);
      chk("reset_border", int'(out_border), 0);

      // Pixels without SOF while idle must be ignored.
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);

      send_pixels(NPIX, 0);
      idle(6);

      nb_cnt = 0;
      send_pixels(NPIX, 35);
      idle(35);
      chk("non_border_windows", nb_cnt, 4);

      send_pixels(40, 0);
      send_pixels(NPIX, 20);
      idle(35);

      send_pixels(NPIX, 0);
      send_pixels(NPIX, 0);
      idle(35);
      chk("frame_done_pulses", fd_cnt, 5);

      send_pixels(NPIX, 0);
      idle(10);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("post_reset_row", int'(out_row), 0);
      chk("post_reset_col", int'(out_col), 0);
      chk("post_reset_busy", int'(busy), 0);
      chk("post_reset_ready", int'(in_ready), 1);
      idle(10);

      chk("queue_empty", exp_q.size(), 0);
      chk("frame_done_total", fd_cnt, 5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule

`default_nettype wire
